// File: rtl/fetch_pc_if.sv
// Bundle between the fetch PC controller and its hazard/branch/imem neighbours.
// The slave modport is the controller; the master modport is its environment.
interface fetch_pc_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        read_en;
  logic        flush;
  logic [31:0] pc_plus4;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        misalign_err;
  logic [15:0] fetch_count;

  modport master (
    output stall, redirect_valid, redirect_pc,
    input  pc, read_en, flush, pc_plus4, if_pc, if_valid, misalign_err, fetch_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc,
    output pc, read_en, flush, pc_plus4, if_pc, if_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program counter and fetch control for a one-cycle-latency instruction memory.
// Tracks the PC belonging to the memory output so IF/ID sees an aligned {if_pc, if_valid}.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  fetch_pc_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] if_pc_r;
  logic        if_valid_r;
  logic        misalign_err_r;
  logic [15:0] fetch_count_r;
  logic        read_en_s;
  logic        flush_s;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Memory read/flush strobes: redirect beats stall, nothing is issued in BOOT or under reset.
  always_comb begin
    read_en_s = 1'b0;
    flush_s   = 1'b0;
    if (state_r == BOOT) begin
      read_en_s = 1'b0;
      flush_s   = 1'b0;
    end else if (bus.redirect_valid) begin
      flush_s   = 1'b1;
    end else if (bus.stall) begin
      read_en_s = 1'b0;
    end else begin
      read_en_s = 1'b1;
    end
  end

  // FSM, PC, IF/ID tag, misalign pulse and saturating fetch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= BOOT;
      pc_r           <= align_word(RESET_PC);
      if_pc_r        <= 32'h0000_0000;
      if_valid_r     <= 1'b0;
      misalign_err_r <= 1'b0;
      fetch_count_r  <= 16'h0000;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
          if (bus.redirect_valid) begin
            pc_r           <= align_word(bus.redirect_pc);
            misalign_err_r <= is_misaligned(bus.redirect_pc);
          end else begin
            misalign_err_r <= 1'b0;
          end
        end
        RUN, HOLD: begin
          if (bus.redirect_valid) begin
            state_r        <= RUN;
            pc_r           <= align_word(bus.redirect_pc);
            if_valid_r     <= 1'b0;
            misalign_err_r <= is_misaligned(bus.redirect_pc);
          end else if (bus.stall) begin
            state_r        <= HOLD;
            misalign_err_r <= 1'b0;
          end else begin
            state_r        <= RUN;
            pc_r           <= pc_r + 32'd4;
            if_pc_r        <= pc_r;
            if_valid_r     <= 1'b1;
            misalign_err_r <= 1'b0;
            if (fetch_count_r != 16'hFFFF) begin
              fetch_count_r <= fetch_count_r + 16'd1;
            end else begin
              fetch_count_r <= fetch_count_r;
            end
          end
        end
        default: begin
          state_r        <= BOOT;
          misalign_err_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc           = pc_r;
  assign bus.pc_plus4     = pc_r + 32'd4;
  assign bus.read_en      = read_en_s;
  assign bus.flush        = flush_s;
  assign bus.if_pc        = if_pc_r;
  assign bus.if_valid     = if_valid_r;
  assign bus.misalign_err = misalign_err_r;
  assign bus.fetch_count  = fetch_count_r;

endmodule
